pd_pwr_ctrl: RTL and testbench

Power-management sequencer for the switchable power domain that holds the two-output datapath instance under the design top. It turns a level sleep request into the ordered isolate → save → switch-off sequence and the reverse switch-on → restore → de-isolate sequence. It drives the isolation, retention and power-switch controls named in the power intent, and waits on the switch acknowledge with settle and timeout counting.

---
 rtl/pd_pwr_ctrl_if.sv | 24 ++
 rtl/pd_pwr_ctrl.sv | 116 +++++++++++
 tb/tb_pd_pwr_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pd_pwr_ctrl_if.sv
// Control bundle between the power-domain requester and its sequencer.
// The sequencer takes the slave side; the requester takes the master side.
interface pd_pwr_ctrl_if;
  logic pd_req;
  logic sw_ack;
  logic err_clr;
  logic pd_ack;
  logic busy;
  logic iso_en;
  logic save;
  logic restore;
  logic pwr_sw_en;
  logic err;

  modport master (
    output pd_req, sw_ack, err_clr,
    input  pd_ack, busy, iso_en, save, restore, pwr_sw_en, err
  );

  modport slave (
    input  pd_req, sw_ack, err_clr,
    output pd_ack, busy, iso_en, save, restore, pwr_sw_en, err
  );
endinterface

// File: rtl/pd_pwr_ctrl.sv
// Power-domain sequencer: isolate/save/switch-off and switch-on/restore/de-isolate.
// Define PD_PWR_CTRL_RET_EN to include the retention SAVE and RESTORE steps.
module pd_pwr_ctrl #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst_n,
  pd_pwr_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ON, ISO, SAVE, PWR_OFF, OFF, PWR_ON, RESTORE, DEISO
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [9:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       pd_ack_q, busy_q, iso_q, sw_q;
  logic       match, wait_st, settled;

  assign match   = (bus.sw_ack == sw_q);
  assign wait_st = (state_q == PWR_OFF) || (state_q == PWR_ON);
  assign settled = match && (settle_q == 8'(SETTLE_CYC - 1));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    err_d    = err_q & ~bus.err_clr;
    if (wait_st) begin
      if (match) begin
        settle_d = settle_q + 8'd1;
      end else begin
        settle_d = 8'd0;
        if (tmo_q != 10'(ACK_TIMEOUT)) tmo_d = tmo_q + 10'd1;
        // A set in the same cycle as err_clr wins
        if (tmo_q == 10'(ACK_TIMEOUT - 1)) err_d = 1'b1;
      end
    end
    unique case (state_q)
      ON:      if (bus.pd_req) state_d = ISO;
`ifdef PD_PWR_CTRL_RET_EN
      ISO:     state_d = SAVE;
`else
      ISO:     state_d = PWR_OFF;
`endif
      SAVE:    state_d = PWR_OFF;
      PWR_OFF: if (settled) state_d = OFF;
      OFF:     if (!bus.pd_req) state_d = PWR_ON;
`ifdef PD_PWR_CTRL_RET_EN
      PWR_ON:  if (settled) state_d = RESTORE;
`else
      PWR_ON:  if (settled) state_d = DEISO;
`endif
      RESTORE: state_d = DEISO;
      DEISO:   state_d = ON;
      default: state_d = ON;
    endcase
    if (state_d != state_q) begin
      settle_d = 8'd0;
      tmo_d    = 10'd0;
    end
  end

  // Outputs are registered from the next state so they align with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ON;
      settle_q <= 8'd0;
      tmo_q    <= 10'd0;
      err_q    <= 1'b0;
      pd_ack_q <= 1'b0;
      busy_q   <= 1'b0;
      iso_q    <= 1'b0;
      sw_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      pd_ack_q <= (state_d == OFF);
      busy_q   <= (state_d != ON) && (state_d != OFF);
      iso_q    <= (state_d != ON);
      sw_q     <= (state_d != PWR_OFF) && (state_d != OFF);
    end
  end

`ifdef PD_PWR_CTRL_RET_EN
  logic save_q, restore_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      save_q    <= 1'b0;
      restore_q <= 1'b0;
    end else begin
      save_q    <= (state_d == SAVE);
      restore_q <= (state_d == RESTORE);
    end
  end

  assign bus.save    = save_q;
  assign bus.restore = restore_q;
`else
  assign bus.save    = 1'b0;
  assign bus.restore = 1'b0;
`endif

  assign bus.pd_ack    = pd_ack_q;
  assign bus.busy      = busy_q;
  assign bus.iso_en    = iso_q;
  assign bus.pwr_sw_en = sw_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pd_pwr_ctrl.sv
// Directed bench for pd_pwr_ctrl; expected output patterns are hand-derived.
// Output vector order: {pd_ack, busy, iso_en, save, restore, pwr_sw_en, err}.
module tb_pd_pwr_ctrl;
  localparam int S = 4;
  localparam int T = 64;

  localparam logic [6:0] P_ON   = 7'b0000010;
  localparam logic [6:0] P_ISO  = 7'b0110010;
  localparam logic [6:0] P_SAVE = 7'b0111010;
  localparam logic [6:0] P_PWOF = 7'b0110000;
  localparam logic [6:0] P_OFF  = 7'b1010000;
  localparam logic [6:0] P_PWON = 7'b0110010;
  localparam logic [6:0] P_REST = 7'b0110110;
  localparam logic [6:0] P_DEIS = 7'b0110010;
  localparam logic [6:0] P_ERR  = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic track;
  logic sw_man;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pd_pwr_ctrl_if ifc ();

  assign ifc.sw_ack = track ? ifc.pwr_sw_en : sw_man;

  pd_pwr_ctrl #(
    .SETTLE_CYC (S),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  wire [6:0] obs = {ifc.pd_ack, ifc.busy, ifc.iso_en, ifc.save,
                    ifc.restore, ifc.pwr_sw_en, ifc.err};

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, e);
    end
  endtask

  task automatic wait_pat(input string tag, input logic [6:0] e,
                          input int max);
    int i;
    i = 0;
    while (obs !== e && i < max) begin
      step();
      i++;
    end
    chk(tag, e);
  endtask

  initial begin
    ifc.pd_req  = 1'b0;
    ifc.err_clr = 1'b0;
    track       = 1'b1;
    sw_man      = 1'b1;
    rst_n       = 1'b0;
    step(2);
    chk("reset", P_ON);
    rst_n = 1'b1;
    step();
    chk("idle_on", P_ON);

    // power-off sequence
    ifc.pd_req = 1'b1;
    chk("off_n", P_ON);
    step();
    chk("off_iso", P_ISO);
`ifdef PD_PWR_CTRL_RET_EN
    step();
    chk("off_save", P_SAVE);
`endif
    step();
    chk("off_pwoff", P_PWOF);
    step(S - 1);
    chk("off_settle", P_PWOF);
    step();
    chk("off_done", P_OFF);
    step(2);
    chk("off_hold", P_OFF);

    // power-on sequence
    ifc.pd_req = 1'b0;
    chk("on_n", P_OFF);
    step();
    chk("on_pwon", P_PWON);
    step(S - 1);
    chk("on_settle", P_PWON);
`ifdef PD_PWR_CTRL_RET_EN
    step();
    chk("on_restore", P_REST);
`endif
    step();
    chk("on_deiso", P_DEIS);
    step();
    chk("on_done", P_ON);

    // sw_ack glitch in PWR_OFF restarts settle
    track      = 1'b0;
    sw_man     = 1'b1;
    ifc.pd_req = 1'b1;
    step();
`ifdef PD_PWR_CTRL_RET_EN
    step();
`endif
    step();
    chk("gl_pwoff", P_PWOF);
    sw_man = 1'b0;
    step(2);
    sw_man = 1'b1;
    step();
    sw_man = 1'b0;
    step(S - 1);
    chk("gl_wait", P_PWOF);
    step();
    chk("gl_off", P_OFF);
    track      = 1'b1;
    ifc.pd_req = 1'b0;
    wait_pat("gl_back_on", P_ON, 20);

    // ack timeout in PWR_OFF
    track      = 1'b0;
    sw_man     = 1'b1;
    ifc.pd_req = 1'b1;
    step();
`ifdef PD_PWR_CTRL_RET_EN
    step();
`endif
    step();
    chk("to_pwoff", P_PWOF);
    step(T - 1);
    chk("to_before", P_PWOF);
    step();
    chk("to_err", P_PWOF | P_ERR);
    ifc.err_clr = 1'b1;
    step();
    ifc.err_clr = 1'b0;
    chk("to_clr", P_PWOF);
    step(3);
    chk("to_stay_clr", P_PWOF);
    sw_man = 1'b0;
    step(S - 1);
    chk("to_settle", P_PWOF);
    step();
    chk("to_off", P_OFF);
    track      = 1'b1;
    ifc.pd_req = 1'b0;
    wait_pat("to_back_on", P_ON, 20);

    // pd_req drops mid-sequence; sequence completes then powers back on
    ifc.pd_req = 1'b1;
    step();
    chk("tg_iso", P_ISO);
`ifdef PD_PWR_CTRL_RET_EN
    step();
    chk("tg_save", P_SAVE);
`endif
    ifc.pd_req = 1'b0;
    step();
    chk("tg_pwoff", P_PWOF);
    step(S - 1);
    chk("tg_settle", P_PWOF);
    step();
    chk("tg_off", P_OFF);
    step();
    chk("tg_pwon", P_PWON);
    wait_pat("tg_back_on", P_ON, 20);

    // async reset mid-settle in PWR_ON with err set
    ifc.pd_req = 1'b1;
    wait_pat("rs_off", P_OFF, 20);
    track      = 1'b0;
    sw_man     = 1'b0;
    ifc.pd_req = 1'b0;
    step();
    chk("rs_pwon", P_PWON);
    step(T);
    chk("rs_err", P_PWON | P_ERR);
    sw_man = 1'b1;
    step(2);
    chk("rs_mid", P_PWON | P_ERR);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async", P_ON);
    step();
    rst_n = 1'b1;
    track = 1'b1;
    step(2);
    chk("rs_after", P_ON);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
